// File: rtl/module_reg_if.sv
// Bus-side signal bundle for module_reg: write/increment strobes, bus data in,
// register content out.
interface module_reg_if #(
    parameter int WIDTH = 8
);
    logic             Wen;
    logic             INC;
    logic [WIDTH-1:0] BusOut;
    logic [WIDTH-1:0] dout;

    modport master (
        output Wen,
        output INC,
        output BusOut,
        input  dout
    );

    modport slave (
        input  Wen,
        input  INC,
        input  BusOut,
        output dout
    );
endinterface : module_reg_if

// File: rtl/module_reg.sv
// Loadable/incrementable datapath register (PC, address, loop counters).
// Define MODULE_REG_SAT_EN to make increments saturate at all-ones instead of wrapping.
module module_reg #(
    parameter int WIDTH = 8
) (
    input logic          Clk,
    input logic          RST,
    module_reg_if.slave  bus
);

    // NOTE: the declaration initialiser gives the FPGA power-up value, so dout
    // is defined before the first reset; it is not an initial block.
    logic [WIDTH-1:0] value_q = '0;
    logic [WIDTH-1:0] value_inc;

`ifdef MODULE_REG_SAT_EN
    assign value_inc = (&value_q) ? value_q : value_q + WIDTH'(1);
`else
    assign value_inc = value_q + WIDTH'(1);
`endif

    // Write beats increment; reset overrides everything without a clock.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            value_q <= '0;
        end else if (bus.Wen) begin
            value_q <= bus.BusOut;
        end else if (bus.INC) begin
            value_q <= value_inc;
        end
    end

    assign bus.dout = value_q;

endmodule : module_reg

// File: tb/tb_module_reg.sv
// Directed self-checking bench for module_reg: load, async reset, increment,
// priority, hold and wrap/saturate.
module tb_module_reg;

    localparam int WIDTH = 8;

    logic Clk;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;

    module_reg_if #(.WIDTH(WIDTH)) bus ();

    module_reg #(.WIDTH(WIDTH)) dut (
        .Clk (Clk),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic edge_step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] wrap1_exp;
        logic [WIDTH-1:0] wrap2_exp;
`ifdef MODULE_REG_SAT_EN
        wrap1_exp = 8'hFF;
        wrap2_exp = 8'hFF;
`else
        wrap1_exp = 8'h00;
        wrap2_exp = 8'h01;
`endif
        RST        = 1'b0;
        bus.Wen    = 1'b0;
        bus.INC    = 1'b0;
        bus.BusOut = '0;

        #2;
        check("powerup", bus.dout, 8'h00);
        RST = 1'b1;
        #1;
        check("reset_initial", bus.dout, 8'h00);
        RST = 1'b0;

        // Load 12, then the later bus value is ignored.
        edge_step();
        bus.Wen = 1'b1; bus.BusOut = 8'd12;
        edge_step();
        check("load_12", bus.dout, 8'd12);
        bus.Wen = 1'b0; bus.BusOut = 8'd8;
        edge_step();
        check("load_hold", bus.dout, 8'd12);

        // Async reset between edges, held while RST=1.
        #2;
        RST = 1'b1;
        #1;
        check("async_reset", bus.dout, 8'h00);
        bus.BusOut = 8'd5;
        edge_step();
        check("reset_held", bus.dout, 8'h00);

        // Increment twice; bus values ignored.
        RST = 1'b0;
        bus.INC = 1'b1; bus.BusOut = 8'd5;
        edge_step();
        check("inc_1", bus.dout, 8'd1);
        bus.BusOut = 8'd34;
        edge_step();
        check("inc_2", bus.dout, 8'd2);
        bus.INC = 1'b0;

        // Reset after counting, stays 0 one cycle after release.
        RST = 1'b1;
        #1;
        check("reset_after_count", bus.dout, 8'h00);
        RST = 1'b0;
        edge_step();
        check("post_release_idle", bus.dout, 8'h00);

        // Write beats increment.
        bus.Wen = 1'b1; bus.INC = 1'b1; bus.BusOut = 8'd34;
        edge_step();
        check("wen_over_inc", bus.dout, 8'd34);
        bus.Wen = 1'b0; bus.INC = 1'b0; bus.BusOut = 8'd99;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check($sformatf("hold_%0d", i), bus.dout, 8'd34);
        end

        // Reset beats write.
        RST = 1'b1; bus.Wen = 1'b1; bus.BusOut = 8'd77;
        #1;
        check("rst_over_wen", bus.dout, 8'h00);
        edge_step();
        check("rst_over_wen_edge", bus.dout, 8'h00);
        RST = 1'b0;
        edge_step();
        check("wen_after_release", bus.dout, 8'd77);
        bus.Wen = 1'b0;

        // k increments advance by k.
        bus.INC = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            edge_step();
            check($sformatf("inc_run_%0d", i), bus.dout, 8'(77 + i));
        end
        bus.INC = 1'b0;

        // Wrap (default) or saturate at all-ones.
        bus.Wen = 1'b1; bus.BusOut = 8'hFF;
        edge_step();
        check("load_ff", bus.dout, 8'hFF);
        bus.Wen = 1'b0; bus.INC = 1'b1;
        edge_step();
        check("inc_from_ff", bus.dout, wrap1_exp);
        edge_step();
        check("inc_after_ff", bus.dout, wrap2_exp);
        bus.INC = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_module_reg
